// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
// Accepts an operand pair over a ready/valid handshake and drives the datapath
// one operation at a time (INIT/ADD/SUB/SHIFT, each followed by NOP). It then
// captures the 2*BIT_LEN product and holds it behind a ready/valid output.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a multiplicand, in_b multiplier
//   dp_in1/dp_in2         latched operands to the datapath
//   dp_op                 registered datapath op code
//   dp_signal             datapath status {B[0], FIN}
//   dp_out                datapath product {X,B}
//   busy                  multiplication in progress
//   out_valid/out_ready   result handshake; result holds the captured product
module booth_seq_ctrl #(
  parameter int unsigned BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_LEN-1:0]     in_a,
  input  logic [BIT_LEN-1:0]     in_b,
  output logic [BIT_LEN-1:0]     dp_in1,
  output logic [BIT_LEN-1:0]     dp_in2,
  output logic [2:0]             dp_op,
  input  logic [1:0]             dp_signal,
  input  logic [2*BIT_LEN-1:0]   dp_out,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BIT_LEN-1:0]   result
);

  localparam int unsigned PW = 2 * BIT_LEN;

  localparam logic [2:0] OP_INIT  = 3'b000;
  localparam logic [2:0] OP_NOP   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DECIDE,
    S_ARITH,
    S_AWAIT,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 qm1_q, qm1_d;
  logic                 sub_q, sub_d;
  logic [BIT_LEN-1:0]   a_q, a_d;
  logic [BIT_LEN-1:0]   b_q, b_d;
  logic [PW-1:0]        result_q, result_d;
  logic [2:0]           dp_op_q, dp_op_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;

  logic                 dp_b0;
  logic                 dp_fin;

  assign dp_b0  = dp_signal[1];
  assign dp_fin = dp_signal[0];

  // Next-state and datapath bookkeeping
  always_comb begin
    state_d  = state_q;
    qm1_d    = qm1_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          qm1_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: state_d = S_DECIDE;
      S_DECIDE: begin
        if (dp_fin) begin
          result_d = dp_out;
          state_d  = S_DONE;
        end else if ({dp_b0, qm1_q} == 2'b10) begin
          sub_d   = 1'b1;
          state_d = S_ARITH;
        end else if ({dp_b0, qm1_q} == 2'b01) begin
          sub_d   = 1'b0;
          state_d = S_ARITH;
        end else begin
          qm1_d   = dp_b0;
          state_d = S_SHIFT;
        end
      end
      S_ARITH: state_d = S_AWAIT;
      // Add/sub only touches X, so B0 is still the bit this step decided on
      S_AWAIT: begin
        qm1_d   = dp_b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: state_d = S_DECIDE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register in step with it
  always_comb begin
    dp_op_d     = OP_NOP;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_d)
      S_IDLE:   in_ready_d = 1'b1;
      S_INIT: begin
        dp_op_d = OP_INIT;
        busy_d  = 1'b1;
      end
      S_DECIDE: busy_d = 1'b1;
      S_ARITH: begin
        dp_op_d = sub_d ? OP_SUB : OP_ADD;
        busy_d  = 1'b1;
      end
      S_AWAIT:  busy_d = 1'b1;
      S_SHIFT: begin
        dp_op_d = OP_SHIFT;
        busy_d  = 1'b1;
      end
      S_DONE:   out_valid_d = 1'b1;
      default:  in_ready_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qm1_q       <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      dp_op_q     <= OP_NOP;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      qm1_q       <= qm1_d;
      sub_q       <= sub_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      dp_op_q     <= dp_op_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dp_in1    = a_q;
  assign dp_in2    = b_q;
  assign dp_op     = dp_op_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Testbench for booth_seq_ctrl: a behavioural Booth datapath drives the status
// inputs. Directed vectors, randomized operands checked against an arithmetic
// reference, and hand-written reset and output-backpressure sequences.
module tb_booth_seq_ctrl;

  localparam int unsigned L  = 4;
  localparam int unsigned PW = 2 * L;
  localparam int unsigned XW = L + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  in_a, in_b;
  logic [L-1:0]  dp_in1, dp_in2;
  logic [2:0]    dp_op;
  logic [1:0]    dp_signal;
  logic [PW-1:0] dp_out;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.BIT_LEN(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_op(dp_op), .dp_signal(dp_signal), .dp_out(dp_out),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  // Behavioural datapath: {X,B} with one guard bit on X, acts on each op code
  logic signed [XW+L-1:0] acc;
  logic [L-1:0]           mcand;
  int                     cnt;

  always @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= L;
    end else begin
      case (dp_op)
        3'b000: begin
          acc   <= {{XW{1'b0}}, dp_in2};
          mcand <= dp_in1;
          cnt   <= L;
        end
        3'b010: acc[XW+L-1:L] <= acc[XW+L-1:L] + {mcand[L-1], mcand};
        3'b011: acc[XW+L-1:L] <= acc[XW+L-1:L] - {mcand[L-1], mcand};
        3'b100: begin
          acc <= acc >>> 1;
          cnt <= cnt - 1;
        end
        default: ;
      endcase
    end
  end

  assign dp_signal = {acc[0], (cnt == 0)};
  assign dp_out    = acc[PW-1:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [L-1:0] a, input logic [L-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return PW'(p);
  endfunction

  // Expected op trace from the Booth recoding of b: one NOP decision per bit,
  // an add/sub (with its NOP) on each bit transition, then a shift.
  task automatic ref_ops(input logic [L-1:0] b, output logic [63:0] sig, output int len);
    logic q;
    sig = 64'(3'b000);
    len = 1;
    q   = 1'b0;
    for (int i = 0; i < int'(L); i++) begin
      sig = (sig << 3) | 64'(3'b001); len++;
      if (b[i] != q) begin
        sig = (sig << 3) | 64'(b[i] ? 3'b011 : 3'b010);
        sig = (sig << 3) | 64'(3'b001);
        len += 2;
      end
      sig = (sig << 3) | 64'(3'b100); len++;
      q = b[i];
    end
    sig = (sig << 3) | 64'(3'b001); len++;
  endtask

  // Accept an operand pair and wait for out_valid, logging dp_op each cycle
  task automatic start_mul(input logic [L-1:0] a, input logic [L-1:0] b,
                           output int lat, output logic [63:0] ops);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ops = '0;
    while (!out_valid && lat < 100) begin
      ops = (ops << 3) | 64'(dp_op);
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_consume", 64'(in_ready), 64'd1);
    check("out_valid_after_consume", 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [L-1:0]  a;
    logic [L-1:0]  b;
    logic [PW-1:0] res;
    int            lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int           lat, exp_len;
    logic [63:0]  ops, exp_ops;
    logic [L-1:0] ra, rb;

    vecs[0] = '{a: 4'd3, b: 4'd3, res: 8'h09, lat: 14};
    vecs[1] = '{a: 4'd7, b: 4'd0, res: 8'h00, lat: 10};
    vecs[2] = '{a: 4'd5, b: 4'd5, res: 8'h19, lat: 18};
    vecs[3] = '{a: 4'h8, b: 4'h8, res: 8'h40, lat: 12};
    vecs[4] = '{a: 4'd3, b: 4'hE, res: 8'hFA, lat: 12};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dp_op", 64'(dp_op), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      start_mul(vecs[i].a, vecs[i].b, lat, ops);
      check("vec_result", 64'(result), 64'(vecs[i].res));
      check("vec_latency", 64'(lat), 64'(vecs[i].lat));
      check("vec_dp_in1", 64'(dp_in1), 64'(vecs[i].a));
      check("vec_dp_in2", 64'(dp_in2), 64'(vecs[i].b));
      ref_ops(vecs[i].b, exp_ops, exp_len);
      check("vec_ops", ops, exp_ops);
      consume();
    end

    // Explicit op trace for 3 x 3
    start_mul(4'd3, 4'd3, lat, ops);
    check("ops_3x3", ops, {10'd0, 3'b000, 3'b001, 3'b011, 3'b001, 3'b100, 3'b001, 3'b100,
                           3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001});
    consume();

    // Randomized operands against the arithmetic reference
    for (int t = 0; t < 40; t++) begin
      ra = L'($urandom_range(0, 15));
      rb = L'($urandom_range(0, 15));
      ref_ops(rb, exp_ops, exp_len);
      start_mul(ra, rb, lat, ops);
      check("rand_result", 64'(result), 64'(ref_prod(ra, rb)));
      check("rand_latency", 64'(lat), 64'(exp_len));
      check("rand_ops", ops, exp_ops);
      consume();
    end

    // Reset in the middle of a multiply discards it
    in_a = 4'd5; in_b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_dp_op", 64'(dp_op), 64'd1);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_dp_in1", 64'(dp_in1), 64'd0);
    start_mul(4'd2, 4'd3, lat, ops);
    check("after_rst_result", 64'(result), 64'h06);
    consume();

    // Backpressure in DONE: everything holds while in_valid is pulsed
    start_mul(4'd3, 4'hE, lat, ops);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = L'($urandom_range(0, 15));
      in_b = L'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("hold_result", 64'(result), 64'hFA);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_dp_in1", 64'(dp_in1), 64'd3);
      check("hold_dp_in2", 64'(dp_in2), 64'hE);
    end
    in_valid = 1'b0;
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
